// File: rtl/gate_bist_ctrl_pkg.sv
// Shared encodings for the universal-gate BIST sequencer: expected-function
// selects, FSM states and a busy-state decode.
package gate_bist_ctrl_pkg;

   localparam logic [1:0] OP_NAND = 2'b00;
   localparam logic [1:0] OP_NOR  = 2'b01;
   localparam logic [1:0] OP_AND  = 2'b10;
   localparam logic [1:0] OP_OR   = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_APPLY  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   function automatic logic is_busy(input state_t s);
      return (s == ST_APPLY) || (s == ST_SETTLE) || (s == ST_SAMPLE);
   endfunction

endpackage

// File: rtl/gate_bist_ctrl_golden.sv
// Golden reference for the gate under test: maps the latched function select
// and the applied vector to the bit the gate should produce.
module gate_golden
   import gate_bist_ctrl_pkg::*;
(
   input  logic [1:0] op,
   input  logic       a,
   input  logic       b,
   output logic       expected
);

   always_comb begin
      case (op)
         OP_NAND: expected = ~(a & b);
         OP_NOR:  expected = ~(a | b);
         OP_AND:  expected = a & b;
         OP_OR:   expected = a | b;
         default: expected = 1'b0;
      endcase
   end

endmodule

// File: rtl/gate_bist_ctrl.sv
// Exhaustive-vector BIST sequencer for one 2-input universal gate: applies
// 00..11, waits a settle interval, samples and scores against the golden gate.
module gate_bist_ctrl
   import gate_bist_ctrl_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int LOOPS         = 1,
   parameter int ERR_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [1:0]       op_sel,
   input  logic             dut_out,
   output logic             inp1,
   output logic             inp2,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [3:0]       fail_vec,
   output logic [ERR_W-1:0] err_count
);

   localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;
   localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
   localparam logic [LOOP_W-1:0] LOOP_LAST   = LOOP_W'(LOOPS - 1);

   state_t            state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [1:0]        vec_q, vec_d;
   logic [LOOP_W-1:0] loop_q, loop_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        inp_q, inp_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [3:0]        fail_q, fail_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic              expected_s;

   gate_golden u_golden (
      .op       (op_q),
      .a        (inp_q[1]),
      .b        (inp_q[0]),
      .expected (expected_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= 2'b00;
         vec_q   <= 2'b00;
         loop_q  <= '0;
         cnt_q   <= '0;
         inp_q   <= 2'b00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= 4'b0000;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         vec_q   <= vec_d;
         loop_q  <= loop_d;
         cnt_q   <= cnt_d;
         inp_q   <= inp_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         err_q   <= err_d;
      end
   end

   // Abort outranks every busy-state transition, including the SAMPLE exit.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_APPLY;
            else       state_d = ST_IDLE;
         end
         ST_APPLY: begin
            if (abort)                   state_d = ST_IDLE;
            else if (SETTLE_CYCLES == 0) state_d = ST_SAMPLE;
            else                         state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (abort)                state_d = ST_IDLE;
            else if (cnt_q == '0)     state_d = ST_SAMPLE;
            else                      state_d = ST_SETTLE;
         end
         ST_SAMPLE: begin
            if (abort)                                        state_d = ST_IDLE;
            else if ((vec_q == 2'd3) && (loop_q == LOOP_LAST)) state_d = ST_DONE;
            else                                              state_d = ST_APPLY;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are computed from the next state so every port comes straight off a flop.
   always_comb begin
      op_d   = op_q;
      vec_d  = vec_q;
      loop_d = loop_q;
      cnt_d  = cnt_q;
      pass_d = pass_q;
      fail_d = fail_q;
      err_d  = err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d   = op_sel;
               vec_d  = 2'b00;
               loop_d = '0;
               pass_d = 1'b0;
               fail_d = 4'b0000;
               err_d  = '0;
            end else begin
               op_d = op_q;
            end
         end
         ST_APPLY:  cnt_d = SETTLE_LOAD;
         ST_SETTLE: begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            else             cnt_d = cnt_q;
         end
         ST_SAMPLE: begin
            if (!abort) begin
               if (dut_out != expected_s) begin
                  fail_d[vec_q] = 1'b1;
                  if (err_q != '1) err_d = err_q + ERR_W'(1);
                  else             err_d = err_q;
               end else begin
                  err_d = err_q;
               end
               vec_d = vec_q + 2'd1;
               if (vec_q == 2'd3) loop_d = loop_q + LOOP_W'(1);
               else               loop_d = loop_q;
            end else begin
               vec_d = vec_q;
            end
         end
         default: ;
      endcase
      if (is_busy(state_q) && abort) pass_d = 1'b0;
      else if (state_d == ST_DONE)   pass_d = (fail_d == 4'b0000);
      else                           pass_d = pass_d;
      busy_d = is_busy(state_d);
      done_d = (state_d == ST_DONE);
      inp_d  = busy_d ? vec_d : 2'b00;
   end

   assign inp1      = inp_q[1];
   assign inp2      = inp_q[0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_vec  = fail_q;
   assign err_count = err_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Scoreboard bench for gate_bist_ctrl: four instances with different settle,
// loop and counter widths, each driving a behavioural NAND (optionally stuck-at-0).
module tb_gate_bist_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] start_s;
   logic [3:0] abort_s;
   logic [1:0] op_sel;
   logic [3:0] stuck;
   logic [3:0] inp1_w, inp2_w, busy_w, done_w, pass_w, dut_out_w;
   logic [3:0] fv_w [4];
   logic [7:0] err_w [4];
   logic [1:0] err_narrow;

   int cyc = 0;
   int checks = 0;
   int failures = 0;
   int cur = 0;
   int start_cyc = 0;
   int busy_cnt = 0;

   typedef struct {
      logic [3:0] fv;
      logic [7:0] err;
      logic       pass;
      int         lat;
      string      name;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 4; g++) begin : g_gate
      assign dut_out_w[g] = stuck[g] ? 1'b0 : ~(inp1_w[g] & inp2_w[g]);
   end

   gate_bist_ctrl #(.SETTLE_CYCLES(2), .LOOPS(1), .ERR_W(8)) u_dut (
      .clk(clk), .rst(rst), .start(start_s[0]), .abort(abort_s[0]), .op_sel(op_sel),
      .dut_out(dut_out_w[0]), .inp1(inp1_w[0]), .inp2(inp2_w[0]), .busy(busy_w[0]),
      .done(done_w[0]), .pass(pass_w[0]), .fail_vec(fv_w[0]), .err_count(err_w[0]));

   gate_bist_ctrl #(.SETTLE_CYCLES(2), .LOOPS(2), .ERR_W(8)) u_dut_l2 (
      .clk(clk), .rst(rst), .start(start_s[1]), .abort(abort_s[1]), .op_sel(op_sel),
      .dut_out(dut_out_w[1]), .inp1(inp1_w[1]), .inp2(inp2_w[1]), .busy(busy_w[1]),
      .done(done_w[1]), .pass(pass_w[1]), .fail_vec(fv_w[1]), .err_count(err_w[1]));

   gate_bist_ctrl #(.SETTLE_CYCLES(0), .LOOPS(1), .ERR_W(8)) u_dut_s0 (
      .clk(clk), .rst(rst), .start(start_s[2]), .abort(abort_s[2]), .op_sel(op_sel),
      .dut_out(dut_out_w[2]), .inp1(inp1_w[2]), .inp2(inp2_w[2]), .busy(busy_w[2]),
      .done(done_w[2]), .pass(pass_w[2]), .fail_vec(fv_w[2]), .err_count(err_w[2]));

   gate_bist_ctrl #(.SETTLE_CYCLES(0), .LOOPS(2), .ERR_W(2)) u_dut_sat (
      .clk(clk), .rst(rst), .start(start_s[3]), .abort(abort_s[3]), .op_sel(op_sel),
      .dut_out(dut_out_w[3]), .inp1(inp1_w[3]), .inp2(inp2_w[3]), .busy(busy_w[3]),
      .done(done_w[3]), .pass(pass_w[3]), .fail_vec(fv_w[3]), .err_count(err_narrow));

   assign err_w[3] = {6'b000000, err_narrow};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout expected=event", name);
   endtask

   // Monitor: every done pulse of the instance under test is scored against the queue.
   always @(negedge clk) begin
      if (busy_w[cur]) busy_cnt++;
      if (done_w[cur]) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=1 expected=0");
         end else begin
            mon_e = sb_q.pop_front();
            check({mon_e.name, "_fail_vec"}, 32'(fv_w[cur]), 32'(mon_e.fv));
            check({mon_e.name, "_err_count"}, 32'(err_w[cur]), 32'(mon_e.err));
            check({mon_e.name, "_pass"}, 32'(pass_w[cur]), 32'(mon_e.pass));
            check({mon_e.name, "_done_cycle"}, 32'(cyc - start_cyc), 32'(mon_e.lat));
         end
      end
   end

   // Latency is the cycle number of done, counting the cycle after the start edge as 1.
   task automatic run(input int idx, input logic [1:0] op, input logic [3:0] fv,
                      input logic [7:0] err, input logic ps, input int lat, input int exp_busy,
                      input bit abort_too, input bit restart_mid, input string name);
      exp_t e;
      bit   got;
      e.fv = fv; e.err = err; e.pass = ps; e.lat = lat; e.name = name;
      sb_q.push_back(e);
      @(negedge clk);
      cur = idx; op_sel = op; start_s[idx] = 1'b1; abort_s[idx] = abort_too;
      busy_cnt = 0; start_cyc = cyc;
      @(negedge clk);
      start_s[idx] = 1'b0; abort_s[idx] = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 200 && !got; n++) begin
         if (restart_mid && n == 4) begin
            start_s[idx] = 1'b1;
            op_sel = 2'b10;
         end else begin
            start_s[idx] = 1'b0;
         end
         if (done_w[idx]) got = 1'b1;
         else             @(negedge clk);
      end
      start_s[idx] = 1'b0;
      if (!got) fail_now({name, "_done_wait"});
      @(negedge clk);
      check({name, "_done_one_cycle"}, 32'(done_w[idx]), 32'd0);
      check({name, "_busy_after"}, 32'(busy_w[idx]), 32'd0);
      check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
      check({name, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
   endtask

   task automatic wait_vec(input logic [1:0] v, input string name);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 100 && !seen; n++) begin
         if (busy_w[0] && ({inp1_w[0], inp2_w[0]} == v)) seen = 1'b1;
         else                                           @(negedge clk);
      end
      if (!seen) fail_now(name);
   endtask

   task automatic check_reset_values(input string name);
      check({name, "_inp1"}, 32'(inp1_w[0]), 32'd0);
      check({name, "_inp2"}, 32'(inp2_w[0]), 32'd0);
      check({name, "_busy"}, 32'(busy_w[0]), 32'd0);
      check({name, "_done"}, 32'(done_w[0]), 32'd0);
      check({name, "_pass"}, 32'(pass_w[0]), 32'd0);
      check({name, "_fail_vec"}, 32'(fv_w[0]), 32'd0);
      check({name, "_err_count"}, 32'(err_w[0]), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start_s = 4'b0000; abort_s = 4'b0000; op_sel = 2'b00;
      stuck = 4'b1010;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset_values("reset");

      // NAND gate scored against each golden function on the SETTLE=2 instance.
      run(0, 2'b00, 4'b0000, 8'd0, 1'b1, 17, 16, 1'b0, 1'b0, "nand_ok");
      run(0, 2'b01, 4'b0110, 8'd2, 1'b0, 17, 16, 1'b0, 1'b0, "nand_vs_nor");
      run(0, 2'b10, 4'b1111, 8'd4, 1'b0, 17, 16, 1'b0, 1'b0, "nand_vs_and");
      run(0, 2'b11, 4'b1001, 8'd2, 1'b0, 17, 16, 1'b0, 1'b0, "nand_vs_or");
      // Stuck-at-0 over two loops, SETTLE=0 with start+abort together, saturation at 2 bits.
      run(1, 2'b00, 4'b0111, 8'd6, 1'b0, 33, 32, 1'b0, 1'b0, "stuck_two_loops");
      run(2, 2'b00, 4'b0000, 8'd0, 1'b1, 9, 8, 1'b1, 1'b0, "settle0");
      run(3, 2'b00, 4'b0111, 8'd3, 1'b0, 17, 16, 1'b0, 1'b0, "err_saturate");
      // Mid-run start pulse with a changed op_sel must not disturb the run.
      run(0, 2'b00, 4'b0000, 8'd0, 1'b1, 17, 16, 1'b0, 1'b1, "restart_mid");

      // Abort in the SAMPLE cycle of vector 2 on a stuck-at-0 gate.
      stuck[0] = 1'b1;
      @(negedge clk);
      cur = 0; op_sel = 2'b00; start_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
      wait_vec(2'b10, "abort_vec2_wait");
      repeat (3) @(negedge clk);
      abort_s[0] = 1'b1;
      @(negedge clk);
      abort_s[0] = 1'b0;
      check("abort_busy", 32'(busy_w[0]), 32'd0);
      check("abort_done", 32'(done_w[0]), 32'd0);
      check("abort_pass", 32'(pass_w[0]), 32'd0);
      check("abort_fail_vec", 32'(fv_w[0]), 32'd3);
      check("abort_err_count", 32'(err_w[0]), 32'd2);
      check("abort_inputs", 32'({inp1_w[0], inp2_w[0]}), 32'd0);
      repeat (20) @(negedge clk);

      // Reset while settling vector 1, then a clean run from scratch.
      start_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
      wait_vec(2'b01, "rst_vec1_wait");
      @(negedge clk);
      check("rst_pre_fail_vec", 32'(fv_w[0]), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_values("rst_in_settle");
      stuck[0] = 1'b0;
      run(0, 2'b00, 4'b0000, 8'd0, 1'b1, 17, 16, 1'b0, 1'b0, "after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
